branch_predict_ctrl: RTL

- Gshare-style branch prediction controller wrapped around a speculative/committed branch-history pair.
- Serves fetch-stage prediction requests from a pattern history table (PHT) of 2-bit saturating counters.
- Tracks in-flight predicted branches in an in-order queue and retires them when execute resolves them.
- On a mispredict or flush, sequences history recovery and stalls prediction for one cycle.

---
 rtl/branch_predict_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/branch_predict_ctrl.sv
// rtl/branch_predict_ctrl.sv - gshare branch predictor with speculative/committed history and in-order resolve queue
// Mispredict or flush rebuilds the speculative history from the committed one and stalls fetch for one cycle.
module branch_predict_ctrl #(
    parameter int         HIST_BITS = 2,
    parameter int         IDX_BITS  = 4,
    parameter int         INFLIGHT  = 2,
    parameter logic [1:0] PHT_INIT  = 2'b01
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         pred_valid,
    input  logic [31:0]                  pred_pc,
    output logic                         pred_ready,
    output logic                         pred_taken,
    input  logic                         res_valid,
    input  logic                         res_taken,
    input  logic                         flush,
    output logic                         mispredict,
    output logic [HIST_BITS-1:0]         bhr_spec,
    output logic [HIST_BITS-1:0]         bhr_commit,
    output logic [$clog2(INFLIGHT):0]    inflight_cnt
);

    localparam int CW      = $clog2(INFLIGHT) + 1;
    localparam int PW      = (INFLIGHT > 1) ? $clog2(INFLIGHT) : 1;
    localparam int ENTRIES = 1 << IDX_BITS;

    typedef enum logic {RUN, RECOVER} state_t;

    state_t              state, state_d;
    logic [1:0]          pht    [ENTRIES];
    logic [IDX_BITS-1:0] q_idx  [INFLIGHT];
    logic                q_pred [INFLIGHT];
    logic [PW-1:0]       head, tail;
    logic [IDX_BITS-1:0] idx;
    logic [IDX_BITS-1:0] head_idx;
    logic [1:0]          head_ctr;
    logic                accept, resolve, recover;
    logic [HIST_BITS-1:0] commit_next;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(INFLIGHT - 1)) ? '0 : p + 1'b1;
    endfunction

    // New outcome enters at the MSB, oldest outcome falls off the LSB.
    function automatic logic [HIST_BITS-1:0] hist_shift(input logic [HIST_BITS-1:0] h,
                                                        input logic b);
        logic [HIST_BITS:0] t;
        t = {b, h};
        return t[HIST_BITS:1];
    endfunction

    always_comb begin
        idx         = pred_pc[IDX_BITS+1:2] ^ IDX_BITS'(bhr_spec);
        pred_taken  = pht[idx][1];
        pred_ready  = (state == RUN) && (inflight_cnt < CW'(INFLIGHT));
        accept      = pred_valid && pred_ready;
        resolve     = res_valid && (inflight_cnt != '0);
        head_idx    = q_idx[head];
        head_ctr    = pht[head_idx];
        mispredict  = resolve && (res_taken != q_pred[head]);
        recover     = mispredict || flush;
        commit_next = resolve ? hist_shift(bhr_commit, res_taken) : bhr_commit;
        state_d     = recover ? RECOVER : RUN;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= RUN;
        else       state <= state_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) pht[i] <= PHT_INIT;
            for (int i = 0; i < INFLIGHT; i++) begin
                q_idx[i]  <= '0;
                q_pred[i] <= 1'b0;
            end
            head         <= '0;
            tail         <= '0;
            inflight_cnt <= '0;
            bhr_spec     <= '0;
            bhr_commit   <= '0;
        end else begin
            if (resolve) begin
                if (res_taken && head_ctr != 2'b11)
                    pht[head_idx] <= head_ctr + 2'd1;
                else if (!res_taken && head_ctr != 2'b00)
                    pht[head_idx] <= head_ctr - 2'd1;
            end
            bhr_commit <= commit_next;
            if (recover) begin
                // Same-cycle accept is dropped; resolve above still trains the PHT.
                head         <= '0;
                tail         <= '0;
                inflight_cnt <= '0;
                bhr_spec     <= commit_next;
            end else begin
                if (accept) begin
                    q_idx[tail]  <= idx;
                    q_pred[tail] <= pred_taken;
                    tail         <= ptr_inc(tail);
                    bhr_spec     <= hist_shift(bhr_spec, pred_taken);
                end
                if (resolve) head <= ptr_inc(head);
                if (accept && !resolve)
                    inflight_cnt <= inflight_cnt + 1'b1;
                else if (!accept && resolve)
                    inflight_cnt <= inflight_cnt - 1'b1;
            end
        end
    end

endmodule
